// File: rtl/touch_i2c_responder_if.sv
// Touch-panel I2C pad bundle: SCL, SDA pad level, SDA open-drain pull, interrupt line.
// Latency: n/a (wires only).
// Backpressure: none; the I2C master paces everything through SCL.
//   touch_scl      master -> target  I2C clock
//   touch_sda_in   master -> target  SDA as seen on the pad (wired-AND of both sides)
//   touch_sda_dir  target -> master  1 = target pulls SDA low
//   touch_int_out  target -> master  touch interrupt pulse
interface touch_i2c_responder_if;
    logic touch_scl;
    logic touch_sda_in;
    logic touch_sda_dir;
    logic touch_int_out;

    modport master (
        output touch_scl,
        output touch_sda_in,
        input  touch_sda_dir,
        input  touch_int_out
    );

    modport slave (
        input  touch_scl,
        input  touch_sda_in,
        output touch_sda_dir,
        output touch_int_out
    );
endinterface

// File: rtl/touch_i2c_responder.sv
// I2C target emulating a GT9147-style touch controller; serves injected (x,y) touches.
// Latency: SDA changes 3 clk after the SCL fall on the pad; a touch commits 2 clk after its strobe when idle.
// Backpressure: injections wait while a bus transaction is open (busy); a later strobe overwrites a pending one.
//   clk, rst_n            system clock, synchronous active-low reset
//   bus (slave modport)   touch_scl / touch_sda_in / touch_sda_dir / touch_int_out
//   touch_set, touch_clr  one-cycle injection strobes; tp_x / tp_y coordinates for touch_set
//   busy                  high from START to STOP
module touch_i2c_responder #(
    parameter logic [6:0]  DEV_ADDR   = 7'h14,
    parameter int          INT_PULSE  = 500,
    parameter logic [31:0] PRODUCT_ID = 32'h39313437
) (
    input  logic                 clk,
    input  logic                 rst_n,
    touch_i2c_responder_if.slave bus,
    input  logic                 touch_set,
    input  logic                 touch_clr,
    input  logic [15:0]          tp_x,
    input  logic [15:0]          tp_y,
    output logic                 busy
);

    localparam int ICW = $clog2(INT_PULSE + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_REG_HI, S_REG_HI_ACK, S_REG_LO, S_REG_LO_ACK,
        S_WR_DATA, S_WR_ACK, S_RD_DATA, S_RD_ACK, S_WAIT
    } state_t;

    state_t state, state_next;

    // Synchronizers reset to 1 so an idle (high) bus produces no spurious edge after reset.
    logic [1:0] scl_sync, sda_sync;
    logic       scl_d, sda_d;
    logic       scl, sda;
    logic       scl_rise, scl_fall, start_c, stop_c;

    logic       sda_dir_q, dir_next;
    logic       busy_q;
    logic [3:0] bit_cnt;
    logic [7:0] rx_byte, tx_byte, ptr_hi, rd_byte;
    logic [15:0] ptr;
    logic       rw_q, mack_q;

    logic       rx_shift, tx_shift, tx_load, cnt_clr;
    logic       rw_load, hi_load, ptr_load, ptr_inc, wr_en, ack_sample;

    logic [7:0]  status;
    logic [15:0] coord_x, coord_y;
    logic        pend_vld, pend_coords;
    logic [7:0]  pend_status;
    logic [15:0] pend_x, pend_y;
    logic        commit;
    logic [ICW-1:0] int_cnt;

    assign scl      = scl_sync[1];
    assign sda      = sda_sync[1];
    assign scl_rise = scl & ~scl_d;
    assign scl_fall = ~scl & scl_d;
    // START/STOP require SCL high on both the current and previous sample.
    assign start_c  = scl & scl_d & sda_d & ~sda;
    assign stop_c   = scl & scl_d & ~sda_d & sda;

    assign bus.touch_sda_dir = sda_dir_q;
    assign bus.touch_int_out = (int_cnt != '0);
    assign busy              = busy_q;

    // Register map read mux
    always_comb begin
        rd_byte = 8'h00;
        case (ptr)
            16'h8140: rd_byte = PRODUCT_ID[31:24];
            16'h8141: rd_byte = PRODUCT_ID[23:16];
            16'h8142: rd_byte = PRODUCT_ID[15:8];
            16'h8143: rd_byte = PRODUCT_ID[7:0];
            16'h814E: rd_byte = status;
            16'h8150: rd_byte = coord_x[7:0];
            16'h8151: rd_byte = coord_x[15:8];
            16'h8152: rd_byte = coord_y[7:0];
            16'h8153: rd_byte = coord_y[15:8];
            default:  rd_byte = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[0], bus.touch_scl};
            sda_sync <= {sda_sync[0], bus.touch_sda_in};
            scl_d    <= scl_sync[1];
            sda_d    <= sda_sync[1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            sda_dir_q <= 1'b0;
        end else begin
            state     <= state_next;
            sda_dir_q <= dir_next;
        end
    end

    // Receive states count SCL rises up to 8; the ACK slot starts on the following fall.
    // RD_DATA counts falls: the byte MSB goes out on the fall that enters it.
    always_comb begin
        state_next = state;
        dir_next   = sda_dir_q;
        rx_shift   = 1'b0;
        tx_shift   = 1'b0;
        tx_load    = 1'b0;
        cnt_clr    = 1'b0;
        rw_load    = 1'b0;
        hi_load    = 1'b0;
        ptr_load   = 1'b0;
        ptr_inc    = 1'b0;
        wr_en      = 1'b0;
        ack_sample = 1'b0;
        if (start_c) begin
            state_next = S_ADDR;
            dir_next   = 1'b0;
            cnt_clr    = 1'b1;
        end else if (stop_c) begin
            state_next = S_IDLE;
            dir_next   = 1'b0;
        end else begin
            case (state)
                S_ADDR, S_REG_HI, S_REG_LO, S_WR_DATA: begin
                    if (scl_rise && bit_cnt != 4'd8) begin
                        rx_shift = 1'b1;
                    end else if (scl_fall && bit_cnt == 4'd8) begin
                        cnt_clr = 1'b1;
                        case (state)
                            S_ADDR: begin
                                if (rx_byte[7:1] == DEV_ADDR) begin
                                    state_next = S_ADDR_ACK;
                                    dir_next   = 1'b1;
                                    rw_load    = 1'b1;
                                end else begin
                                    state_next = S_IDLE;
                                end
                            end
                            S_REG_HI: begin
                                state_next = S_REG_HI_ACK;
                                dir_next   = 1'b1;
                                hi_load    = 1'b1;
                            end
                            S_REG_LO: begin
                                state_next = S_REG_LO_ACK;
                                dir_next   = 1'b1;
                                ptr_load   = 1'b1;
                            end
                            default: begin
                                state_next = S_WR_ACK;
                                dir_next   = 1'b1;
                                wr_en      = 1'b1;
                                ptr_inc    = 1'b1;
                            end
                        endcase
                    end
                end
                S_ADDR_ACK: begin
                    if (scl_fall) begin
                        if (rw_q) begin
                            state_next = S_RD_DATA;
                            tx_load    = 1'b1;
                            cnt_clr    = 1'b1;
                            dir_next   = ~rd_byte[7];
                        end else begin
                            state_next = S_REG_HI;
                            dir_next   = 1'b0;
                        end
                    end
                end
                S_REG_HI_ACK: begin
                    if (scl_fall) begin
                        state_next = S_REG_LO;
                        dir_next   = 1'b0;
                    end
                end
                S_REG_LO_ACK, S_WR_ACK: begin
                    if (scl_fall) begin
                        state_next = S_WR_DATA;
                        dir_next   = 1'b0;
                    end
                end
                S_RD_DATA: begin
                    if (scl_fall) begin
                        if (bit_cnt == 4'd7) begin
                            state_next = S_RD_ACK;
                            dir_next   = 1'b0;
                            ptr_inc    = 1'b1;
                            cnt_clr    = 1'b1;
                        end else begin
                            tx_shift = 1'b1;
                            dir_next = ~tx_byte[6];
                        end
                    end
                end
                S_RD_ACK: begin
                    if (scl_rise) begin
                        ack_sample = 1'b1;
                    end else if (scl_fall) begin
                        if (mack_q) begin
                            state_next = S_RD_DATA;
                            tx_load    = 1'b1;
                            cnt_clr    = 1'b1;
                            dir_next   = ~rd_byte[7];
                        end else begin
                            state_next = S_WAIT;
                            dir_next   = 1'b0;
                        end
                    end
                end
                default: begin
                    state_next = state;
                end
            endcase
        end
    end

    assign commit = pend_vld & ~busy_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q      <= 1'b0;
            bit_cnt     <= 4'd0;
            rx_byte     <= 8'h00;
            tx_byte     <= 8'h00;
            ptr_hi      <= 8'h00;
            ptr         <= 16'h0000;
            rw_q        <= 1'b0;
            mack_q      <= 1'b0;
            status      <= 8'h00;
            coord_x     <= 16'h0000;
            coord_y     <= 16'h0000;
            pend_vld    <= 1'b0;
            pend_coords <= 1'b0;
            pend_status <= 8'h00;
            pend_x      <= 16'h0000;
            pend_y      <= 16'h0000;
            int_cnt     <= '0;
        end else begin
            if (start_c) begin
                busy_q <= 1'b1;
            end else if (stop_c) begin
                busy_q <= 1'b0;
            end

            if (cnt_clr) begin
                bit_cnt <= 4'd0;
            end else if (rx_shift || tx_shift) begin
                bit_cnt <= bit_cnt + 4'd1;
            end

            if (rx_shift)   rx_byte <= {rx_byte[6:0], sda};
            if (tx_load)    tx_byte <= rd_byte;
            else if (tx_shift) tx_byte <= {tx_byte[6:0], 1'b0};
            if (rw_load)    rw_q    <= rx_byte[0];
            if (hi_load)    ptr_hi  <= rx_byte;
            if (ack_sample) mack_q  <= ~sda;

            if (ptr_load) begin
                ptr <= {ptr_hi, rx_byte};
            end else if (ptr_inc) begin
                ptr <= ptr + 16'd1;
            end

            if (wr_en && ptr == 16'h814E) begin
                status <= rx_byte;
            end

            // Commit is placed after the bus write so it wins a same-cycle collision.
            if (commit) begin
                status   <= pend_status;
                pend_vld <= 1'b0;
                int_cnt  <= ICW'(INT_PULSE);
                if (pend_coords) begin
                    coord_x <= pend_x;
                    coord_y <= pend_y;
                end
            end else if (int_cnt != '0) begin
                int_cnt <= int_cnt - 1'b1;
            end

            // A new strobe lands after the commit clear so it stays pending.
            if (touch_set) begin
                pend_vld    <= 1'b1;
                pend_coords <= 1'b1;
                pend_status <= 8'h81;
                pend_x      <= tp_x;
                pend_y      <= tp_y;
            end else if (touch_clr) begin
                pend_vld    <= 1'b1;
                pend_coords <= 1'b0;
                pend_status <= 8'h80;
            end
        end
    end

endmodule

// File: tb/tb_touch_i2c_responder.sv
module tb_touch_i2c_responder;

    localparam time Q = 100;

    logic        clk;
    logic        rst_n;
    logic        scl_m;
    logic        m_sda;
    logic        touch_set;
    logic        touch_clr;
    logic [15:0] tp_x;
    logic [15:0] tp_y;
    logic        busy;

    int checks;
    int failures;

    logic [7:0] exp_q[$];
    logic       rd_phase;
    logic       watch_dir;
    logic       dir_seen;

    touch_i2c_responder_if bus();

    assign bus.touch_scl    = scl_m;
    assign bus.touch_sda_in = m_sda & ~bus.touch_sda_dir;

    touch_i2c_responder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .touch_set (touch_set),
        .touch_clr (touch_clr),
        .tp_x      (tp_x),
        .tp_y      (tp_y),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Read-data monitor: collects the 8 bits of each read byte at SCL rise and scores them.
    initial begin : monitor
        logic [7:0] sh;
        logic [7:0] e;
        int n;
        sh = 8'h00;
        n = 0;
        forever begin
            @(posedge bus.touch_scl);
            #1;
            if (rd_phase) begin
                sh = {sh[6:0], bus.touch_sda_in};
                n++;
                if (n == 8) begin
                    n = 0;
                    checks++;
                    if (exp_q.size() == 0) begin
                        failures++;
                        $display("FAIL rd_byte unexpected got=%02h", sh);
                    end else begin
                        e = exp_q.pop_front();
                        if (sh !== e) begin
                            failures++;
                            $display("FAIL rd_byte got=%02h expected=%02h t=%0t", sh, e, $time);
                        end
                    end
                end
            end
        end
    end

    initial begin : dir_watch
        forever begin
            @(negedge clk);
            if (watch_dir && bus.touch_sda_dir) dir_seen = 1'b1;
        end
    end

    task automatic i2c_start();
        m_sda = 1'b1; #Q;
        scl_m = 1'b1; #Q;
        m_sda = 1'b0; #Q;
        scl_m = 1'b0; #Q;
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0; #Q;
        scl_m = 1'b1; #Q;
        m_sda = 1'b1; #Q;
    endtask

    task automatic wbit(input logic b);
        m_sda = b;    #Q;
        scl_m = 1'b1; #(2*Q);
        scl_m = 1'b0; #Q;
    endtask

    task automatic rbit(output logic b);
        m_sda = 1'b1; #Q;
        scl_m = 1'b1; #Q;
        b = bus.touch_sda_in; #Q;
        scl_m = 1'b0; #Q;
    endtask

    task automatic wbyte(input logic [7:0] d, input logic exp_ack);
        logic a;
        for (int i = 7; i >= 0; i--) wbit(d[i]);
        rbit(a);
        check("ack", {31'd0, ~a}, {31'd0, exp_ack});
    endtask

    task automatic rbyte(input logic last);
        logic b;
        rd_phase = 1'b1;
        for (int i = 0; i < 8; i++) rbit(b);
        rd_phase = 1'b0;
        wbit(last);
    endtask

    task automatic set_ptr(input logic [15:0] a);
        i2c_start();
        wbyte(8'h28, 1'b1);
        wbyte(a[15:8], 1'b1);
        wbyte(a[7:0], 1'b1);
    endtask

    task automatic rd_regs(input logic [15:0] a, input int n);
        set_ptr(a);
        i2c_start();
        wbyte(8'h29, 1'b1);
        for (int i = 0; i < n; i++) rbyte(i == n - 1);
        i2c_stop();
        repeat (5) @(negedge clk);
    endtask

    task automatic wr_reg(input logic [15:0] a, input logic [7:0] d);
        set_ptr(a);
        wbyte(d, 1'b1);
        i2c_stop();
        repeat (5) @(negedge clk);
    endtask

    task automatic pulse(input logic s, input logic c, input logic [15:0] x, input logic [15:0] y);
        @(negedge clk);
        touch_set = s; touch_clr = c; tp_x = x; tp_y = y;
        @(negedge clk);
        touch_set = 1'b0; touch_clr = 1'b0;
    endtask

    task automatic push4(input logic [31:0] v);
        exp_q.push_back(v[31:24]);
        exp_q.push_back(v[23:16]);
        exp_q.push_back(v[15:8]);
        exp_q.push_back(v[7:0]);
    endtask

    initial begin : stim
        int w;
        int hi_cnt;
        checks = 0; failures = 0;
        rd_phase = 1'b0; watch_dir = 1'b0; dir_seen = 1'b0;
        rst_n = 1'b0; scl_m = 1'b1; m_sda = 1'b1;
        touch_set = 1'b0; touch_clr = 1'b0; tp_x = 16'h0; tp_y = 16'h0;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_sda_dir", {31'd0, bus.touch_sda_dir}, 32'd0);
        check("rst_int", {31'd0, bus.touch_int_out}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);

        // Product ID read with repeated START, NACK on the last byte
        push4(32'h39313437);
        set_ptr(16'h8140);
        i2c_start();
        wbyte(8'h29, 1'b1);
        for (int i = 0; i < 4; i++) rbyte(i == 3);
        repeat (5) @(negedge clk);
        check("nack_release", {31'd0, bus.touch_sda_dir}, 32'd0);
        check("busy_in_txn", {31'd0, busy}, 32'd1);
        i2c_stop();
        repeat (5) @(negedge clk);
        check("busy_after_stop", {31'd0, busy}, 32'd0);

        // Touch injection and interrupt pulse width
        pulse(1'b1, 1'b0, 16'h01E0, 16'h0110);
        w = 0;
        while (!bus.touch_int_out && w < 10) begin @(negedge clk); w++; end
        check("int_rise", {31'd0, bus.touch_int_out}, 32'd1);
        hi_cnt = 0;
        while (bus.touch_int_out && hi_cnt < 1000) begin @(negedge clk); hi_cnt++; end
        check("int_width", hi_cnt, 32'd500);
        exp_q.push_back(8'h81);
        rd_regs(16'h814E, 1);
        push4(32'hE0011001);
        rd_regs(16'h8150, 4);

        // Status write clears ready; injection held while busy
        wr_reg(16'h814E, 8'h00);
        exp_q.push_back(8'h00);
        rd_regs(16'h814E, 1);
        set_ptr(16'h814E);
        pulse(1'b1, 1'b0, 16'h1234, 16'h5678);
        repeat (10) @(negedge clk);
        check("held_busy", {31'd0, busy}, 32'd1);
        check("held_int", {31'd0, bus.touch_int_out}, 32'd0);
        exp_q.push_back(8'h00);
        i2c_start();
        wbyte(8'h29, 1'b1);
        rbyte(1'b1);
        i2c_stop();
        repeat (5) @(negedge clk);
        check("commit_int", {31'd0, bus.touch_int_out}, 32'd1);
        exp_q.push_back(8'h81);
        rd_regs(16'h814E, 1);
        push4(32'h34127856);
        rd_regs(16'h8150, 4);

        // Foreign address: never acknowledged, busy until STOP, no write effect
        watch_dir = 1'b1; dir_seen = 1'b0;
        i2c_start();
        wbyte(8'h2A, 1'b0);
        wbyte(8'h81, 1'b0);
        wbyte(8'h4E, 1'b0);
        wbyte(8'h00, 1'b0);
        check("foreign_busy", {31'd0, busy}, 32'd1);
        i2c_stop();
        repeat (5) @(negedge clk);
        watch_dir = 1'b0;
        check("foreign_no_drive", {31'd0, dir_seen}, 32'd0);
        check("foreign_busy_clr", {31'd0, busy}, 32'd0);
        exp_q.push_back(8'h81);
        rd_regs(16'h814E, 1);

        // Pointer wrap and unmapped accesses
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h00);
        rd_regs(16'hFFFF, 2);
        wr_reg(16'h1234, 8'h55);
        exp_q.push_back(8'h00);
        rd_regs(16'h1234, 1);

        // STOP in the middle of a data byte
        set_ptr(16'h814E);
        wbit(1'b1); wbit(1'b0); wbit(1'b1);
        i2c_stop();
        repeat (5) @(negedge clk);
        check("stop_mid_dir", {31'd0, bus.touch_sda_dir}, 32'd0);
        check("stop_mid_busy", {31'd0, busy}, 32'd0);
        exp_q.push_back(8'h81);
        rd_regs(16'h814E, 1);

        // Release keeps coordinates; simultaneous set+clr resolves to set
        pulse(1'b0, 1'b1, 16'hFFFF, 16'hFFFF);
        repeat (3) @(negedge clk);
        exp_q.push_back(8'h80);
        rd_regs(16'h814E, 1);
        push4(32'h34127856);
        rd_regs(16'h8150, 4);
        pulse(1'b1, 1'b1, 16'h0102, 16'h0304);
        repeat (3) @(negedge clk);
        exp_q.push_back(8'h81);
        rd_regs(16'h814E, 1);
        push4(32'h02010403);
        rd_regs(16'h8150, 4);

        // Reset while the target is driving a 0 data bit
        set_ptr(16'h8150);
        i2c_start();
        wbyte(8'h29, 1'b1);
        @(negedge clk);
        check("rd_drive_low", {31'd0, bus.touch_sda_dir}, 32'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("rst_mid_dir", {31'd0, bus.touch_sda_dir}, 32'd0);
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        check("rst_mid_int", {31'd0, bus.touch_int_out}, 32'd0);
        @(negedge clk);
        m_sda = 1'b1; #Q;
        scl_m = 1'b1; #Q;
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        exp_q.push_back(8'h00);
        rd_regs(16'h814E, 1);
        push4(32'h00000000);
        rd_regs(16'h8150, 4);

        w = 0;
        while (exp_q.size() != 0 && w < 100) begin @(negedge clk); w++; end
        check("scoreboard_drained", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
